// File: rtl/param_queue_pkg.sv
// Shared types and helpers for the parametrised push/pop queue.
package param_queue_pkg;

  typedef enum logic [0:0] {
    QMODE_FIFO = 1'b0,
    QMODE_LIFO = 1'b1
  } qmode_e;

  // Width able to hold every occupancy value from 0 to depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_queue_ptr.sv
// Up/down pointer for param_queue; WRAP=1 wraps 0..DEPTH-1, WRAP=0 counts 0..DEPTH unwrapped.
module param_queue_ptr
  import param_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter bit          WRAP  = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_inc,
  input  logic                         i_dec,
  output logic [$clog2(DEPTH+1)-1:0]   o_ptr
);

  localparam int unsigned   PW   = count_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_d;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    w_ptr_d = r_ptr;
    if (i_inc && !i_dec) begin
      w_ptr_d = (WRAP && (r_ptr == LAST)) ? '0 : r_ptr + PW'(1);
    end else if (i_dec && !i_inc) begin
      w_ptr_d = (WRAP && (r_ptr == '0)) ? LAST : r_ptr - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_d;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/param_queue.sv
// Parametrised single-clock FIFO/LIFO queue with registered pop data and error pulses.
// Define QUEUE_HWM_EN to add the max_count high-water-mark output.
module param_queue
  import param_queue_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned MODE  = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       pop_valid,
  output logic [DW-1:0]              last_value,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
`ifdef QUEUE_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] max_count
`endif
);

  localparam int unsigned CW    = count_width(DEPTH);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam qmode_e      QMODE = qmode_e'(MODE[0]);

  if (MODE > 1) begin : g_bad_mode
    $error("param_queue: MODE must be 0 (FIFO) or 1 (LIFO)");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_queue: DEPTH must be 2 or more");
  end

  logic [DW-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_d;
  logic [DW-1:0] r_pop_data;
  logic          r_pop_valid;
  logic          r_overflow;
  logic          r_underflow;
  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_new_idx;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full queue still takes a push when a pop frees a slot in the same cycle.
  assign w_push_ok = push && (!w_full || pop);
  assign w_pop_ok  = pop && !w_empty;

  if (QMODE == QMODE_FIFO) begin : g_fifo
    logic [CW-1:0] w_wr_ptr;
    logic [CW-1:0] w_rd_ptr;

    param_queue_ptr #(
      .DEPTH (DEPTH),
      .WRAP  (1'b1)
    ) u_wr_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_push_ok),
      .i_dec   (1'b0),
      .o_ptr   (w_wr_ptr)
    );

    param_queue_ptr #(
      .DEPTH (DEPTH),
      .WRAP  (1'b1)
    ) u_rd_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_pop_ok),
      .i_dec   (1'b0),
      .o_ptr   (w_rd_ptr)
    );

    assign w_wr_idx  = AW'(w_wr_ptr);
    assign w_rd_idx  = AW'(w_rd_ptr);
    assign w_new_idx = (w_wr_ptr == '0) ? AW'(DEPTH - 1) : AW'(w_wr_ptr - CW'(1));
  end else begin : g_lifo
    logic [CW-1:0] w_sp;
    logic [AW-1:0] w_top_idx;

    // sp runs 0..DEPTH, so it must not wrap.
    param_queue_ptr #(
      .DEPTH (DEPTH),
      .WRAP  (1'b0)
    ) u_sp (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_push_ok),
      .i_dec   (w_pop_ok),
      .o_ptr   (w_sp)
    );

    assign w_top_idx = AW'(w_sp - CW'(1));
    // On a push+pop swap the pushed word replaces the popped top slot.
    assign w_wr_idx  = w_pop_ok ? w_top_idx : AW'(w_sp);
    assign w_rd_idx  = w_top_idx;
    assign w_new_idx = w_top_idx;
  end

  always_comb begin
    w_count_d = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_d;
      r_pop_valid <= w_pop_ok;
      r_overflow  <= push && !w_push_ok;
      r_underflow <= pop && w_empty;
      if (w_pop_ok) begin
        r_pop_data <= r_mem[w_rd_idx];
      end
    end
  end

`ifdef QUEUE_HWM_EN
  logic [CW-1:0] r_max_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_max_count <= '0;
    end else if (w_count_d > r_max_count) begin
      r_max_count <= w_count_d;
    end
  end

  assign max_count = r_max_count;
`endif

  assign pop_data   = r_pop_data;
  assign pop_valid  = r_pop_valid;
  assign last_value = w_empty ? '0 : r_mem[w_new_idx];
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_param_queue.sv
// Directed bench for param_queue: one FIFO and one LIFO instance, DW=8, DEPTH=4.
module tb_param_queue;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       f_push = 1'b0, f_pop = 1'b0;
  logic [7:0] f_push_data = '0;
  logic [7:0] f_pop_data, f_last_value;
  logic [2:0] f_count;
  logic       f_pop_valid, f_full, f_empty, f_overflow, f_underflow;

  logic       l_push = 1'b0, l_pop = 1'b0;
  logic [7:0] l_push_data = '0;
  logic [7:0] l_pop_data, l_last_value;
  logic [2:0] l_count;
  logic       l_pop_valid, l_full, l_empty, l_overflow, l_underflow;

`ifdef QUEUE_HWM_EN
  logic [2:0] f_max_count, l_max_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_queue #(.DW(8), .DEPTH(4), .MODE(0)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (f_push),
    .push_data  (f_push_data),
    .pop        (f_pop),
    .pop_data   (f_pop_data),
    .pop_valid  (f_pop_valid),
    .last_value (f_last_value),
    .count      (f_count),
    .full       (f_full),
    .empty      (f_empty),
    .overflow   (f_overflow),
    .underflow  (f_underflow)
`ifdef QUEUE_HWM_EN
    ,
    .max_count  (f_max_count)
`endif
  );

  param_queue #(.DW(8), .DEPTH(4), .MODE(1)) u_lifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (l_push),
    .push_data  (l_push_data),
    .pop        (l_pop),
    .pop_data   (l_pop_data),
    .pop_valid  (l_pop_valid),
    .last_value (l_last_value),
    .count      (l_count),
    .full       (l_full),
    .empty      (l_empty),
    .overflow   (l_overflow),
    .underflow  (l_underflow)
`ifdef QUEUE_HWM_EN
    ,
    .max_count  (l_max_count)
`endif
  );

  // Drive one cycle on the FIFO, leave outputs settled 1 time unit past the edge.
  task automatic tick_f(input logic ps, input logic [7:0] d, input logic pp);
    f_push = ps; f_push_data = d; f_pop = pp;
    @(posedge clk); #1;
    f_push = 1'b0; f_pop = 1'b0;
  endtask

  task automatic tick_l(input logic ps, input logic [7:0] d, input logic pp);
    l_push = ps; l_push_data = d; l_pop = pp;
    @(posedge clk); #1;
    l_push = 1'b0; l_pop = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    total++; if (f_count !== 3'd0) begin bad++; $display("FAIL rst_f_count got=%0d exp=0", f_count); end
    total++; if (f_empty !== 1'b1 || f_full !== 1'b0) begin bad++;
      $display("FAIL rst_f_flags got empty=%b full=%b exp empty=1 full=0", f_empty, f_full); end
    total++; if (f_last_value !== 8'h00 || f_pop_data !== 8'h00) begin bad++;
      $display("FAIL rst_f_data got last=%h pop=%h exp 00/00", f_last_value, f_pop_data); end
    total++; if ({f_pop_valid, f_overflow, f_underflow} !== 3'b000) begin bad++;
      $display("FAIL rst_f_pulses got=%b exp=000", {f_pop_valid, f_overflow, f_underflow}); end
    total++; if (l_count !== 3'd0 || l_empty !== 1'b1 || l_last_value !== 8'h00) begin bad++;
      $display("FAIL rst_l got count=%0d empty=%b last=%h exp 0/1/00", l_count, l_empty, l_last_value); end
    reset_n = 1'b1;
  endtask

  task automatic test_fifo_order;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    for (int i = 0; i < 3; i++) tick_f(1'b1, exp_d[i], 1'b0);
    total++; if (f_count !== 3'd3 || f_last_value !== 8'h33 || f_pop_valid !== 1'b0) begin bad++;
      $display("FAIL fifo_fill got count=%0d last=%h pv=%b exp 3/33/0", f_count, f_last_value, f_pop_valid); end
    for (int i = 0; i < 3; i++) begin
      tick_f(1'b0, 8'h00, 1'b1);
      total++;
      if (f_pop_valid !== 1'b1 || f_pop_data !== exp_d[i] || f_count !== 3'(2 - i)) begin bad++;
        $display("FAIL fifo_pop%0d got pv=%b data=%h count=%0d exp 1/%h/%0d",
                 i, f_pop_valid, f_pop_data, f_count, exp_d[i], 2 - i); end
    end
    total++; if (f_last_value !== 8'h00 || f_empty !== 1'b1) begin bad++;
      $display("FAIL fifo_drained got last=%h empty=%b exp 00/1", f_last_value, f_empty); end
    tick_f(1'b0, 8'h00, 1'b0);
    total++; if (f_pop_valid !== 1'b0 || f_pop_data !== 8'h33) begin bad++;
      $display("FAIL fifo_hold got pv=%b data=%h exp 0/33", f_pop_valid, f_pop_data); end
  endtask

  task automatic test_lifo_order;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hA3; exp_d[1] = 8'hA2; exp_d[2] = 8'hA1;
    for (int i = 2; i >= 0; i--) tick_l(1'b1, exp_d[i], 1'b0);
    total++; if (l_count !== 3'd3 || l_last_value !== 8'hA3) begin bad++;
      $display("FAIL lifo_fill got count=%0d last=%h exp 3/a3", l_count, l_last_value); end
    for (int i = 0; i < 3; i++) begin
      tick_l(1'b0, 8'h00, 1'b1);
      total++;
      if (l_pop_valid !== 1'b1 || l_pop_data !== exp_d[i] || l_count !== 3'(2 - i)) begin bad++;
        $display("FAIL lifo_pop%0d got pv=%b data=%h count=%0d exp 1/%h/%0d",
                 i, l_pop_valid, l_pop_data, l_count, exp_d[i], 2 - i); end
    end
    total++; if (l_empty !== 1'b1 || l_last_value !== 8'h00) begin bad++;
      $display("FAIL lifo_drained got empty=%b last=%h exp 1/00", l_empty, l_last_value); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h02; exp_d[1] = 8'h03; exp_d[2] = 8'h04; exp_d[3] = 8'h66;
    for (int i = 1; i <= 4; i++) tick_f(1'b1, 8'(i), 1'b0);
    total++; if (f_full !== 1'b1 || f_count !== 3'd4 || f_last_value !== 8'h04) begin bad++;
      $display("FAIL ovf_full got full=%b count=%0d last=%h exp 1/4/04", f_full, f_count, f_last_value); end
    tick_f(1'b1, 8'h55, 1'b0);
    total++; if (f_overflow !== 1'b1 || f_count !== 3'd4 || f_last_value !== 8'h04) begin bad++;
      $display("FAIL ovf_pulse got ovf=%b count=%0d last=%h exp 1/4/04", f_overflow, f_count, f_last_value); end
    tick_f(1'b1, 8'h66, 1'b1);
    total++;
    if (f_overflow !== 1'b0 || f_pop_valid !== 1'b1 || f_pop_data !== 8'h01 ||
        f_count !== 3'd4 || f_last_value !== 8'h66) begin bad++;
      $display("FAIL ovf_swap got ovf=%b pv=%b data=%h count=%0d last=%h exp 0/1/01/4/66",
               f_overflow, f_pop_valid, f_pop_data, f_count, f_last_value); end
    for (int i = 0; i < 4; i++) begin
      tick_f(1'b0, 8'h00, 1'b1);
      total++; if (f_pop_data !== exp_d[i] || f_pop_valid !== 1'b1) begin bad++;
        $display("FAIL ovf_drain%0d got data=%h pv=%b exp %h/1", i, f_pop_data, f_pop_valid, exp_d[i]); end
    end
  endtask

  task automatic test_underflow;
    tick_f(1'b0, 8'h00, 1'b1);
    total++; if (f_underflow !== 1'b1 || f_pop_valid !== 1'b0 || f_count !== 3'd0) begin bad++;
      $display("FAIL udf_pulse got udf=%b pv=%b count=%0d exp 1/0/0", f_underflow, f_pop_valid, f_count); end
    tick_f(1'b1, 8'h77, 1'b1);
    total++;
    if (f_underflow !== 1'b1 || f_pop_valid !== 1'b0 || f_count !== 3'd1 || f_last_value !== 8'h77) begin
      bad++;
      $display("FAIL udf_push got udf=%b pv=%b count=%0d last=%h exp 1/0/1/77",
               f_underflow, f_pop_valid, f_count, f_last_value); end
    tick_f(1'b0, 8'h00, 1'b1);
    total++; if (f_underflow !== 1'b0 || f_pop_data !== 8'h77 || f_empty !== 1'b1) begin bad++;
      $display("FAIL udf_pop got udf=%b data=%h empty=%b exp 0/77/1", f_underflow, f_pop_data, f_empty); end
  endtask

  task automatic test_lifo_swap;
    tick_l(1'b1, 8'h10, 1'b0);
    tick_l(1'b1, 8'h20, 1'b0);
    tick_l(1'b1, 8'h30, 1'b1);
    total++;
    if (l_pop_valid !== 1'b1 || l_pop_data !== 8'h20 || l_count !== 3'd2 || l_last_value !== 8'h30) begin
      bad++;
      $display("FAIL lswap got pv=%b data=%h count=%0d last=%h exp 1/20/2/30",
               l_pop_valid, l_pop_data, l_count, l_last_value); end
    tick_l(1'b0, 8'h00, 1'b1);
    total++; if (l_pop_data !== 8'h30 || l_last_value !== 8'h10) begin bad++;
      $display("FAIL lswap_pop1 got data=%h last=%h exp 30/10", l_pop_data, l_last_value); end
    tick_l(1'b0, 8'h00, 1'b1);
    total++; if (l_pop_data !== 8'h10 || l_empty !== 1'b1) begin bad++;
      $display("FAIL lswap_pop2 got data=%h empty=%b exp 10/1", l_pop_data, l_empty); end
    for (int i = 1; i <= 4; i++) tick_l(1'b1, 8'(i), 1'b0);
    tick_l(1'b1, 8'h55, 1'b0);
    total++; if (l_overflow !== 1'b1 || l_count !== 3'd4 || l_last_value !== 8'h04) begin bad++;
      $display("FAIL lovf got ovf=%b count=%0d last=%h exp 1/4/04", l_overflow, l_count, l_last_value); end
    tick_l(1'b1, 8'h66, 1'b1);
    total++;
    if (l_overflow !== 1'b0 || l_pop_data !== 8'h04 || l_count !== 3'd4 || l_last_value !== 8'h66) begin
      bad++;
      $display("FAIL lfull_swap got ovf=%b data=%h count=%0d last=%h exp 0/04/4/66",
               l_overflow, l_pop_data, l_count, l_last_value); end
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i <= 3; i++) tick_f(1'b1, 8'(8'hC0 + i), 1'b0);
    f_pop = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (f_count !== 3'd0 || f_empty !== 1'b1 || f_pop_valid !== 1'b0 || f_pop_data !== 8'h00) begin
      bad++;
      $display("FAIL rmid got count=%0d empty=%b pv=%b data=%h exp 0/1/0/00",
               f_count, f_empty, f_pop_valid, f_pop_data); end
    @(posedge clk); #1;
    total++; if (f_pop_valid !== 1'b0 || f_last_value !== 8'h00) begin bad++;
      $display("FAIL rmid_edge got pv=%b last=%h exp 0/00", f_pop_valid, f_last_value); end
    f_pop = 1'b0;
    reset_n = 1'b1;
`ifdef QUEUE_HWM_EN
    total++; if (f_max_count !== 3'd0) begin bad++;
      $display("FAIL hwm_rst got=%0d exp=0", f_max_count); end
`endif
    for (int i = 1; i <= 3; i++) tick_f(1'b1, 8'(8'hD0 + i), 1'b0);
`ifdef QUEUE_HWM_EN
    total++; if (f_max_count !== 3'd3) begin bad++;
      $display("FAIL hwm_3 got=%0d exp=3", f_max_count); end
`endif
    tick_f(1'b0, 8'h00, 1'b1);
    total++; if (f_pop_data !== 8'hD1 || f_count !== 3'd2) begin bad++;
      $display("FAIL rmid_after got data=%h count=%0d exp d1/2", f_pop_data, f_count); end
`ifdef QUEUE_HWM_EN
    total++; if (f_max_count !== 3'd3) begin bad++;
      $display("FAIL hwm_hold got=%0d exp=3", f_max_count); end
`endif
  endtask

  initial begin
    test_reset;
    test_fifo_order;
    test_lifo_order;
    test_overflow;
    test_underflow;
    test_lifo_swap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
